// File: rtl/a2d_pkg.sv
// Shared constants and helpers for the SPI A2D converter model.
// Channel numbers, frame geometry and the command-word channel decode.
package a2d_pkg;

    localparam logic [2:0] CH_BATT   = 3'd0;
    localparam logic [2:0] CH_CURR   = 3'd1;
    localparam logic [2:0] CH_BRAKE  = 3'd3;
    localparam logic [2:0] CH_TORQUE = 3'd4;

    localparam int FRAME_BITS  = 16;
    localparam int CHNL_MSB    = 13;
    localparam int CHNL_LSB    = 11;
    localparam int RES_BITS    = 12;
    localparam int CNT_W       = 5;
    localparam int SYNC_STAGES = 2;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

    typedef struct packed {
        logic [RES_BITS-1:0] batt;
        logic [RES_BITS-1:0] curr;
        logic [RES_BITS-1:0] brake;
        logic [RES_BITS-1:0] torque;
    } analog_t;

    // Only the channel field of a command word carries meaning.
    function automatic logic [2:0] cmd_chnl(input logic [FRAME_BITS-1:0] cmd);
        return cmd[CHNL_MSB:CHNL_LSB];
    endfunction

endpackage

// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave framer: input synchronisers, edge detect, rx/tx shifters
// and a saturating bit counter. Flags a complete 16-bit frame on SS_n rise.
module spi_slave_frame
    import a2d_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic [FRAME_BITS-1:0] tx_load,
    output logic                  miso,
    output logic                  frame_done,
    output logic [FRAME_BITS-1:0] rx_word
);

    logic [2:0]             ss_sync;
    logic [2:0]             sclk_sync;
    logic [1:0]             mosi_sync;
    logic [SYNC_STAGES:0]   vld_pipe;
    logic                   settled;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic                   in_frame;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_BITS-1:0]  rx_sr;
    logic [FRAME_BITS-1:0]  tx_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
            vld_pipe  <= '0;
        end else begin
            ss_sync   <= {ss_sync[1:0], ss_n};
            sclk_sync <= {sclk_sync[1:0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are trusted only once the sync chain holds real samples again,
    // so a reset while SS_n is low cannot fake an SS_n fall mid-frame.
    assign settled   = vld_pipe[SYNC_STAGES];
    assign ss_fall   = settled & ~ss_sync[1] &  ss_sync[2];
    assign ss_rise   = settled &  ss_sync[1] & ~ss_sync[2];
    assign sclk_rise = settled &  sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = settled & ~sclk_sync[1] &  sclk_sync[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_frame <= 1'b0;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
        end else if (ss_fall) begin
            in_frame <= 1'b1;
            bit_cnt  <= '0;
            tx_sr    <= tx_load;
        end else if (ss_rise) begin
            in_frame <= 1'b0;
        end else if (in_frame) begin
            if (sclk_rise && bit_cnt != FULL_CNT) begin
                rx_sr   <= {rx_sr[FRAME_BITS-2:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (sclk_fall)
                tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign frame_done = ss_rise & in_frame & (bit_cnt == FULL_CNT);
    assign rx_word    = rx_sr;
    assign miso       = in_frame & tx_sr[FRAME_BITS-1];

endmodule

// File: rtl/a2d_analog_model.sv
// 8-channel 12-bit SPI A2D model: each complete frame commands a channel and
// reads back the conversion latched by the previous complete frame.
module a2d_analog_model
    import a2d_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                SCLK,
    input  logic                MOSI,
    output logic                MISO,
    input  logic [RES_BITS-1:0] BATT,
    input  logic [RES_BITS-1:0] CURR,
    input  logic [RES_BITS-1:0] BRAKE,
    input  logic [RES_BITS-1:0] TORQUE
);

    analog_t                ana;
    logic [RES_BITS-1:0]    result;
    logic [RES_BITS-1:0]    chnl_val;
    logic [2:0]             chnl;
    logic [FRAME_BITS-1:0]  rx_word;
    logic [FRAME_BITS-1:0]  tx_load;
    logic                   frame_done;

    assign ana     = '{batt: BATT, curr: CURR, brake: BRAKE, torque: TORQUE};
    assign chnl    = cmd_chnl(rx_word);
    assign tx_load = {{(FRAME_BITS-RES_BITS){1'b0}}, result};

    always_comb begin
        chnl_val = '0;
        case (chnl)
            CH_BATT:   chnl_val = ana.batt;
            CH_CURR:   chnl_val = ana.curr;
            CH_BRAKE:  chnl_val = ana.brake;
            CH_TORQUE: chnl_val = ana.torque;
            default:   chnl_val = '0;
        endcase
    end

    // The analog value is captured at command completion; later input
    // changes must not disturb the pending readback.
    always_ff @(posedge clk) begin
        if (!rst_n)
            result <= '0;
        else if (frame_done)
            result <= chnl_val;
    end

    spi_slave_frame u_frame (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_n       (SS_n),
        .sclk       (SCLK),
        .mosi       (MOSI),
        .tx_load    (tx_load),
        .miso       (MISO),
        .frame_done (frame_done),
        .rx_word    (rx_word)
    );

endmodule

// File: tb/tb_a2d_analog_model.sv
// Directed bench for the SPI A2D model: command/readback pairs, unused
// channels, late analog changes, aborted/overlong frames and mid-frame reset.
module tb_a2d_analog_model;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n, SCLK, MOSI;
    logic        MISO;
    logic [11:0] BATT, CURR, BRAKE, TORQUE;

    int total = 0;
    int bad   = 0;
    logic [15:0] rd;

    a2d_analog_model dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .BATT   (BATT),
        .CURR   (CURR),
        .BRAKE  (BRAKE),
        .TORQUE (TORQUE)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One SPI transaction of nbits SCLK pulses; bits past 16 drive MOSI=1.
    task automatic spi_xfer(input logic [15:0] cmd, input int nbits, output logic [15:0] word);
        word = 16'h0000;
        SS_n = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? cmd[15-i] : 1'b1;
            tick(5);
            if (i < 16) word[15-i] = MISO;
            SCLK = 1'b1;
            tick(5);
            SCLK = 1'b0;
        end
        tick(6);
        SS_n = 1'b1;
        tick(8);
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        BATT = 12'h000; CURR = 12'h000; BRAKE = 12'h000; TORQUE = 12'h000;
        tick(4);
        check("reset_miso", {15'h0, MISO}, 16'h0000);
        rst_n = 1'b1;
        tick(6);

        // first frame after reset, then BATT readback pipeline
        spi_xfer(16'h0000, 16, rd); check("first_frame", rd, 16'h0000);
        BATT = 12'hABC;
        spi_xfer(16'h0000, 16, rd); check("batt_old", rd, 16'h0000);

        CURR = 12'h123; BRAKE = 12'h456; TORQUE = 12'h789;
        spi_xfer(16'h0800, 16, rd); check("rd_batt", rd, 16'h0ABC);
        spi_xfer(16'h1800, 16, rd); check("rd_curr", rd, 16'h0123);
        spi_xfer(16'h2000, 16, rd); check("rd_brake", rd, 16'h0456);
        spi_xfer(16'h1000, 16, rd); check("rd_torque", rd, 16'h0789);
        spi_xfer(16'h3800, 16, rd); check("rd_ch2", rd, 16'h0000);
        spi_xfer(16'h0000, 16, rd); check("rd_ch7", rd, 16'h0000);

        // BATT changes after the ch0 command has latched
        BATT = 12'h555;
        spi_xfer(16'h0800, 16, rd); check("batt_latched", rd, 16'h0ABC);
        spi_xfer(16'h2000, 9, rd);
        spi_xfer(16'h0000, 16, rd); check("after_abort", rd, 16'h0123);
        spi_xfer(16'h0800, 16, rd); check("batt_new", rd, 16'h0555);

        // overlong frame: the two extra SCLK rises must not shift the command
        spi_xfer(16'h2000, 18, rd); check("overlong_rd", rd, 16'h0123);
        spi_xfer(16'h0000, 16, rd); check("overlong_cmd", rd, 16'h0789);

        // reset in the middle of a frame commanding ch1
        SS_n = 1'b0;
        tick(6);
        rd = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            MOSI = (i == 4) ? 1'b1 : 1'b0;
            tick(5);
            if (i == 5) begin
                rst_n = 1'b0;
                tick(2);
                check("midrst_miso", {15'h0, MISO}, 16'h0000);
                rst_n = 1'b1;
            end
            if (i >= 5) rd[15-i] = MISO;
            SCLK = 1'b1;
            tick(5);
            SCLK = 1'b0;
        end
        tick(6);
        SS_n = 1'b1;
        tick(8);
        check("midrst_tail", rd, 16'h0000);
        spi_xfer(16'h2000, 16, rd); check("post_rst_rd", rd, 16'h0000);
        spi_xfer(16'h0000, 16, rd); check("post_rst_torque", rd, 16'h0789);
        spi_xfer(16'h0000, 16, rd); check("post_rst_batt", rd, 16'h0555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
